// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared geometry, tag-field layout and FSM state encoding for the data-cache
// tag controller.
//
// Address layout: <page[31:PSL]> <index[LSH:5]> <word[4:2]> <byte[1:0]>
// Tag layout:     {V[TS-1], D[TS-2], page[TS-3:0]}
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int NL    = 512;          // number of 32-byte cache lines
  localparam int LSS   = 9;            // line-select bits, log2(NL)
  localparam int LSH   = LSS + 4;      // high bit of the line index
  localparam int PSL   = LSH + 1;      // low bit of the page field
  localparam int TS    = 2 + (32 - PSL); // tag width
  localparam int PW    = TS - 2;       // page field width

  localparam int V_BIT   = TS - 1;
  localparam int D_BIT   = TS - 2;
  localparam int PAGE_HI = TS - 3;
  localparam int PAGE_LO = 0;

  localparam int BEATS = 8;            // words per line, one per memory beat

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    EVICT  = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4
  } state_e;

  typedef logic [LSS-1:0] index_t;
  typedef logic [PW-1:0]  page_t;
  typedef logic [TS-1:0]  tag_t;

  function automatic tag_t make_tag(input logic v, input logic d, input page_t page);
    return {v, d, page};
  endfunction

endpackage

// File: rtl/dcache_tag_cmp.sv
// -----------------------------------------------------------------------------
// dcache_tag_cmp
// Combinational tag compare for one looked-up line.
//
// Ports:
//   i_tag          in  TS  tag word read from the tag RAM
//   i_page         in  PW  page field of the CPU address
//   o_hit          out 1   line valid and page matches
//   o_victim_dirty out 1   line valid and dirty (needs writeback on replace)
// -----------------------------------------------------------------------------
module dcache_tag_cmp
  import dcache_pkg::*;
(
  input  logic [TS-1:0] i_tag,
  input  logic [PW-1:0] i_page,
  output logic          o_hit,
  output logic          o_victim_dirty
);

  assign o_hit          = i_tag[V_BIT] & (i_tag[PAGE_HI:PAGE_LO] == i_page);
  assign o_victim_dirty = i_tag[V_BIT] & i_tag[D_BIT];

endmodule

// File: rtl/dcache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_tag_ctrl
// Tag-memory controller for the data cache. Owns every tag-RAM select, flags
// hit/miss for the core, stalls the core on a miss while it runs the line
// fill burst (and, in write-back builds, the victim writeback burst), and
// clears the whole tag RAM after reset.
//
// Build option: define DCACHE_WRITEBACK_EN for a write-back cache (dirty bit
// maintained, dirty victims evicted). Undefined gives write-through: D is
// always written 0 and EVICT is never entered.
//
// Ports:
//   nGCLK       in  1    clock, posedge
//   nRESET      in  1    asynchronous active-low reset
//   cpu_req     in  1    CPU access valid
//   cpu_wr      in  1    access is a write
//   cpu_addr    in  32   CPU byte address
//   cpu_stall   out 1    hold the core
//   cpu_hit     out 1    lookup hit (IDLE only)
//   read_sel    out LSS  tag RAM read line (async read)
//   read_port   in  TS   tag RAM read data
//   write_sel   out LSS  tag RAM write line
//   write_port  out TS   tag RAM write data
//   wr_ena      out 1    tag RAM write enable, captured on next posedge
//   mem_req     out 1    external burst request
//   mem_wr      out 1    1 = writeback burst, 0 = fill burst
//   mem_addr    out 32   current beat address, word aligned
//   mem_ack     in  1    one beat accepted/returned
//   line_we     out 1    data RAM word write (fill beats)
//   line_word   out 3    word index within the line
//
// Outputs are decoded from the registered state and counters; the core-facing
// and beat-facing strobes react in the same cycle as their inputs.
// -----------------------------------------------------------------------------
module dcache_tag_ctrl
  import dcache_pkg::*;
(
  input  logic           nGCLK,
  input  logic           nRESET,
  input  logic           cpu_req,
  input  logic           cpu_wr,
  input  logic [31:0]    cpu_addr,
  output logic           cpu_stall,
  output logic           cpu_hit,
  output logic [LSS-1:0] read_sel,
  input  logic [TS-1:0]  read_port,
  output logic [LSS-1:0] write_sel,
  output logic [TS-1:0]  write_port,
  output logic           wr_ena,
  output logic           mem_req,
  output logic           mem_wr,
  output logic [31:0]    mem_addr,
  input  logic           mem_ack,
  output logic           line_we,
  output logic [2:0]     line_word
);

`ifdef DCACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  state_e     r_state;
  index_t     r_init_cnt;
  logic [2:0] r_beat;
  index_t     r_index;
  page_t      r_page;
  page_t      r_victim_page;
  logic       r_wr;

  index_t w_cpu_index;
  page_t  w_cpu_page;
  logic   w_tag_hit;
  logic   w_victim_dirty;
  logic   w_miss;
  logic   w_set_dirty;
  logic   w_last_ack;
  logic   w_unused_offset;

  assign w_cpu_index = cpu_addr[LSH:5];
  assign w_cpu_page  = cpu_addr[31:PSL];
  // Byte/word offset plays no part in the tag lookup.
  assign w_unused_offset = ^cpu_addr[4:0];

  dcache_tag_cmp u_cmp (
    .i_tag          (read_port),
    .i_page         (w_cpu_page),
    .o_hit          (w_tag_hit),
    .o_victim_dirty (w_victim_dirty)
  );

  assign read_sel  = w_cpu_index;
  assign line_word = r_beat;
  assign cpu_hit   = (r_state == IDLE) & cpu_req & w_tag_hit;
  assign w_miss    = (r_state == IDLE) & cpu_req & ~w_tag_hit;
  // First write to a clean line marks it dirty in the same cycle (write-back).
  assign w_set_dirty = WB_EN & cpu_hit & cpu_wr & ~read_port[D_BIT];
  assign w_last_ack  = mem_ack & (r_beat == 3'(BEATS - 1));

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_stall  = 1'b1;
    wr_ena     = 1'b0;
    write_sel  = w_cpu_index;
    write_port = '0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    line_we    = 1'b0;
    unique case (r_state)
      INIT: begin
        // NOTE: the state register already sits in INIT while reset is held;
        // gating with nRESET keeps the clear-write off until reset releases.
        wr_ena    = nRESET;
        write_sel = r_init_cnt;
      end
      IDLE: begin
        cpu_stall = cpu_req & ~w_tag_hit;
        if (w_set_dirty) begin
          wr_ena     = 1'b1;
          write_port = make_tag(1'b1, 1'b1, w_cpu_page);
        end
      end
      EVICT: begin
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = {r_victim_page, r_index, r_beat, 2'b00};
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_page, r_index, r_beat, 2'b00};
        line_we  = mem_ack;
      end
      UPDATE: begin
        wr_ena     = 1'b1;
        write_sel  = r_index;
        write_port = make_tag(1'b1, r_wr & WB_EN, r_page);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state       <= INIT;
      r_init_cnt    <= '0;
      r_beat        <= '0;
      r_index       <= '0;
      r_page        <= '0;
      r_victim_page <= '0;
      r_wr          <= 1'b0;
    end else begin
      unique case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + LSS'(1);
          if (r_init_cnt == LSS'(NL - 1)) r_state <= IDLE;
        end
        IDLE: begin
          if (w_miss) begin
            // The request is held stable, but latching keeps the burst and
            // tag update correct even if the core drops cpu_req mid-miss.
            r_index       <= w_cpu_index;
            r_page        <= w_cpu_page;
            r_victim_page <= read_port[PAGE_HI:PAGE_LO];
            r_wr          <= cpu_wr;
            r_beat        <= '0;
            r_state       <= (WB_EN & w_victim_dirty) ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (mem_ack) begin
            r_beat <= r_beat + 3'd1;   // wraps to 0 for the following fill
            if (w_last_ack) r_state <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            r_beat <= r_beat + 3'd1;
            if (w_last_ack) r_state <= UPDATE;
          end
        end
        UPDATE:  r_state <= IDLE;
        default: r_state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_tag_ctrl
// Self-checking bench for dcache_tag_ctrl. Holds a behavioural tag RAM and a
// line-level cache model (valid/dirty/page per index) that predicts hit/miss,
// burst addresses and tag updates for each access.
// -----------------------------------------------------------------------------
module tb_dcache_tag_ctrl;
  import dcache_pkg::*;

`ifdef DCACHE_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic           nGCLK = 1'b0;
  logic           nRESET = 1'b0;
  logic           cpu_req = 1'b0;
  logic           cpu_wr = 1'b0;
  logic [31:0]    cpu_addr = '0;
  logic           cpu_stall, cpu_hit;
  logic [LSS-1:0] read_sel, write_sel;
  logic [TS-1:0]  read_port, write_port;
  logic           wr_ena, mem_req, mem_wr, line_we;
  logic [31:0]    mem_addr;
  logic           mem_ack = 1'b0;
  logic [2:0]     line_word;

  int n_checks = 0;
  int n_fail   = 0;

  // Line-level reference model
  bit          m_valid [NL];
  bit          m_dirty [NL];
  logic [PW-1:0] m_page [NL];

  // Behavioural tag RAM: async read, write on posedge
  logic [TS-1:0] tag_ram [NL];
  logic          scramble = 1'b0;

  always #5 nGCLK = ~nGCLK;

  assign read_port = tag_ram[read_sel];

  always @(posedge nGCLK) begin
    if (scramble) begin
      for (int i = 0; i < NL; i++) tag_ram[i] <= TS'($urandom);
    end else if (wr_ena) begin
      tag_ram[write_sel] <= write_port;
    end
  end

  dcache_tag_ctrl dut (
    .nGCLK      (nGCLK),
    .nRESET     (nRESET),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_stall  (cpu_stall),
    .cpu_hit    (cpu_hit),
    .read_sel   (read_sel),
    .read_port  (read_port),
    .write_sel  (write_sel),
    .write_port (write_port),
    .wr_ena     (wr_ena),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .line_we    (line_we),
    .line_word  (line_word)
  );

  task automatic step();
    @(posedge nGCLK);
    #1;
  endtask

  task automatic check_ram(input logic [LSS-1:0] idx);
    n_checks++;
    if (tag_ram[idx] !== {m_valid[idx], m_dirty[idx], m_page[idx]}) begin
      n_fail++;
      $display("FAIL tag_line[%0d]: got %h want %h", idx, tag_ram[idx],
               {m_valid[idx], m_dirty[idx], m_page[idx]});
    end
  endtask

  // Entered with nRESET low; releases reset and checks the full clear pass.
  task automatic run_init();
    int bad, first_bad, nz;
    bad = 0; first_bad = -1; nz = 0;
    @(negedge nGCLK);
    n_checks++;
    if ({cpu_stall, mem_req, mem_wr, wr_ena, line_we} !== 5'b10000 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: stall/req/wr/wr_ena/line_we=%b addr=%h want 10000 addr=0",
               {cpu_stall, mem_req, mem_wr, wr_ena, line_we}, mem_addr);
    end
    step();
    nRESET = 1'b1;
    for (int c = 0; c < NL; c++) begin
      mem_ack = 1'($urandom);
      @(negedge nGCLK);
      if (wr_ena !== 1'b1 || write_sel !== LSS'(c) || write_port !== '0 ||
          cpu_stall !== 1'b1 || mem_req !== 1'b0 || line_we !== 1'b0) begin
        if (first_bad < 0) first_bad = c;
        bad++;
      end
      step();
    end
    mem_ack = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL init_sweep: %0d bad cycles (first %0d), want 0", bad, first_bad);
    end
    @(negedge nGCLK);
    n_checks++;
    if ({wr_ena, cpu_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_init: wr_ena/stall=%b want 00", {wr_ena, cpu_stall});
    end
    for (int i = 0; i < NL; i++) if (tag_ram[i] !== '0) nz++;
    n_checks++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL init_cleared: %0d nonzero lines, want 0", nz);
    end
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_page[i] = '0;
    end
    step();
  endtask

  task automatic burst(input bit is_wb, input logic [PW+LSS-1:0] line,
                       input int max_gap, input bit drop_req);
    int gap;
    logic [31:0] exp_addr;
    for (int b = 0; b < BEATS; b++) begin
      gap = int'($urandom_range(max_gap, 0));
      exp_addr = {line, 3'(b), 2'b00};
      for (int g = 0; g <= gap; g++) begin
        mem_ack = (g == gap);
        @(negedge nGCLK);
        n_checks++;
        if ({mem_req, mem_wr, line_we, cpu_stall} !== {1'b1, is_wb, mem_ack & ~is_wb, 1'b1} ||
            mem_addr !== exp_addr || (mem_ack && line_word !== 3'(b))) begin
          n_fail++;
          $display("FAIL beat%0d(wb=%0b): req/wr/we/stall=%b addr=%h word=%0d want %b addr=%h word=%0d",
                   b, is_wb, {mem_req, mem_wr, line_we, cpu_stall}, mem_addr, line_word,
                   {1'b1, is_wb, mem_ack & ~is_wb, 1'b1}, exp_addr, b);
        end
        step();
      end
      mem_ack = 1'b0;
      if (drop_req && b == 3) cpu_req = 1'b0;
    end
  endtask

  // One CPU access; starts and ends just after a posedge.
  task automatic do_access(input logic [31:0] addr, input logic wr,
                           input int max_gap, input bit drop_req);
    logic [LSS-1:0] idx;
    logic [PW-1:0]  pg, vpg;
    bit exp_hit, evict, set_d;
    logic [2:0] exp_after;
    idx = addr[LSH:5];
    pg  = addr[31:PSL];
    exp_hit = m_valid[idx] && (m_page[idx] == pg);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; mem_ack = 1'b0;
    @(negedge nGCLK);
    n_checks++;
    if ({cpu_hit, cpu_stall} !== {exp_hit, ~exp_hit}) begin
      n_fail++;
      $display("FAIL lookup %h: hit/stall=%b want %b", addr, {cpu_hit, cpu_stall}, {exp_hit, ~exp_hit});
    end
    if (exp_hit) begin
      set_d = WB && wr && !m_dirty[idx];
      n_checks++;
      if (wr_ena !== set_d || (set_d && {write_sel, write_port} !== {idx, 2'b11, pg})) begin
        n_fail++;
        $display("FAIL write_hit %h: wr_ena=%b sel=%0d port=%h want wr_ena=%b sel=%0d port=%h",
                 addr, wr_ena, write_sel, write_port, set_d, idx, {2'b11, pg});
      end
      if (set_d) m_dirty[idx] = 1'b1;
      step();
      @(negedge nGCLK);
      n_checks++;
      if ({cpu_hit, cpu_stall, wr_ena} !== 3'b100) begin
        n_fail++;
        $display("FAIL hit_hold %h: hit/stall/wr_ena=%b want 100", addr, {cpu_hit, cpu_stall, wr_ena});
      end
      step();
      cpu_req = 1'b0;
    end else begin
      evict = WB && m_valid[idx] && m_dirty[idx];
      vpg   = m_page[idx];
      step();
      if (evict) burst(1'b1, {vpg, idx}, max_gap, 1'b0);
      burst(1'b0, {pg, idx}, max_gap, drop_req);
      @(negedge nGCLK);
      n_checks++;
      if ({wr_ena, mem_req, cpu_stall, cpu_hit} !== 4'b1010 || write_sel !== idx ||
          write_port !== {1'b1, wr & WB, pg}) begin
        n_fail++;
        $display("FAIL update %h: wr_ena/req/stall/hit=%b sel=%0d port=%h want 1010 sel=%0d port=%h",
                 addr, {wr_ena, mem_req, cpu_stall, cpu_hit}, write_sel, write_port,
                 idx, {1'b1, wr & WB, pg});
      end
      m_valid[idx] = 1'b1; m_page[idx] = pg; m_dirty[idx] = wr && WB;
      step();
      @(negedge nGCLK);
      exp_after = drop_req ? 3'b000 : 3'b100;
      n_checks++;
      if ({cpu_hit, cpu_stall, wr_ena} !== exp_after) begin
        n_fail++;
        $display("FAIL post_fill %h: hit/stall/wr_ena=%b want %b", addr, {cpu_hit, cpu_stall, wr_ena}, exp_after);
      end
      step();
      cpu_req = 1'b0;
    end
    check_ram(idx);
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    scramble = 1'b1;
    step();
    scramble = 1'b0;
    run_init();
  endtask

  task automatic test_read_miss();
    do_access(32'h0000_4020, 1'b0, 0, 1'b0);
    n_checks++;
    if (tag_ram[1] !== 20'h8_0001) begin
      n_fail++;
      $display("FAIL read_miss_tag: line1=%h want 80001", tag_ram[1]);
    end
  endtask

  task automatic test_replace();
    do_access(32'h0000_8020, 1'b0, 1, 1'b0);
    n_checks++;
    if (tag_ram[1] !== 20'h8_0002) begin
      n_fail++;
      $display("FAIL replace_tag: line1=%h want 80002", tag_ram[1]);
    end
  endtask

  task automatic test_write_policy();
    logic [TS-1:0] exp_tag;
    do_access(32'h0000_4020, 1'b0, 0, 1'b0);
    do_access(32'h0000_4024, 1'b1, 0, 1'b0);
    exp_tag = WB ? 20'hC_0001 : 20'h8_0001;
    n_checks++;
    if (tag_ram[1] !== exp_tag) begin
      n_fail++;
      $display("FAIL write_hit_tag: line1=%h want %h", tag_ram[1], exp_tag);
    end
    // Write-back: dirty victim page 1 is evicted before page 2 fills.
    do_access(32'h0000_8020, 1'b0, 2, 1'b0);
    // Write miss fills like a read miss (D set only in write-back).
    do_access(32'h0000_C040, 1'b1, 1, 1'b0);
  endtask

  task automatic test_ack_gaps();
    do_access(32'h0001_0060, 1'b0, 5, 1'b0);
    do_access(32'h0002_0060, 1'b1, 5, 1'b0);
    // Core drops the request mid-fill; burst and tag write still complete.
    do_access(32'h0003_0080, 1'b0, 3, 1'b1);
  endtask

  task automatic test_idle_ack();
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      @(negedge nGCLK);
      n_checks++;
      if ({mem_req, line_we, wr_ena, cpu_stall, cpu_hit} !== 5'b00000) begin
        n_fail++;
        $display("FAIL idle_ack: req/we/wr_ena/stall/hit=%b want 00000",
                 {mem_req, line_we, wr_ena, cpu_stall, cpu_hit});
      end
      step();
    end
    mem_ack = 1'b0;
    do_access(32'h0003_0080, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom_range(3, 0) << PSL) | ($urandom_range(3, 0) << 5) | ($urandom_range(7, 0) << 2);
      do_access(addr, 1'($urandom), 3, ($urandom_range(7, 0) == 0));
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] addr;
    logic [LSS-1:0] idx;
    int bad;
    addr = 32'hFFFF_C0A0;
    idx  = addr[LSH:5];
    bad  = 0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
    step();
    if (WB && m_valid[idx] && m_dirty[idx]) burst(1'b1, {m_page[idx], idx}, 0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    #2;
    nRESET = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_wr, wr_ena, line_we, cpu_stall} !== 5'b00001 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: req/wr/wr_ena/we/stall=%b addr=%h want 00001 addr=0",
               {mem_req, mem_wr, wr_ena, line_we, cpu_stall}, mem_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge nGCLK);
      if (wr_ena !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_hold_wr_ena: %0d cycles high, want 0", bad);
    end
    check_ram(idx);
    cpu_req = 1'b0;
    run_init();
    do_access(addr, 1'b0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_replace();
    test_write_policy();
    test_ack_gaps();
    test_idle_ack();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
